// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the datapath width defaults, the RV32I load/store funct3 codes,
// the FSM state encoding and two small decode helpers: width legality
// and natural alignment.
package mem_stage_lsu_pkg;

  localparam int LSU_DATA_WIDTH = 32;
  localparam int LSU_ADDR_WIDTH = 32;
  localparam int LSU_RD_WIDTH   = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } lsu_state_e;

  // A width code is legal only for exactly one of load/store, and stores
  // have no unsigned variants.
  function automatic logic lsu_width_ok(input logic       is_load,
                                        input logic       is_store,
                                        input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (is_load && is_store) begin
      ok = 1'b0;
    end else if (is_store) begin
      case (funct3)
        F3_B, F3_H, F3_W: ok = 1'b1;
        default:          ok = 1'b0;
      endcase
    end else if (is_load) begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        default:                        ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // funct3[1:0] carries the access size for both signed and unsigned codes.
  function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane alignment for 32-bit load/store traffic (purely combinational).
// Ports:
//   addr_lo    - byte offset within the word (addr[1:0])
//   funct3     - RV32I load/store width code
//   store_data - rs2 value to be stored
//   rdata      - word returned by memory
//   wstrb      - byte write strobes for the store
//   wdata      - store data replicated across all lanes
//   load_data  - selected and sign/zero-extended load result
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store strobes and lane replication; memory picks the lanes via wstrb.
  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        if (addr_lo[1]) begin
          wstrb = 4'b1100;
        end else begin
          wstrb = 4'b0011;
        end
        wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: begin
        wstrb = 4'b0000;
        wdata = store_data;
      end
    endcase
  end

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Sign- or zero-extend the selected lane to a full register value.
  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'h000000, byte_s};
      F3_HU:   load_data = {16'h0000, half_s};
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: runs RV32I loads/stores on a req/ack memory port and
// produces a registered writeback bundle.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   ex_*                  - EX bundle (valid, load/store, funct3, address/ALU
//                           result, store data, rd, write enable)
//   flush                 - suppress writeback/exception of the bundle in flight
//   stall                 - upstream must hold its bundle (accept cycle + wait)
//   mem_req/we/addr/wstrb/wdata, mem_ack/rdata - data-memory handshake
//   wb_valid/write/reg/data - writeback bundle (one-cycle pulse)
//   mem_exc               - misaligned/illegal access pulse
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int RD_WIDTH   = LSU_RD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_load,
  input  logic                  ex_store,
  input  logic [2:0]            ex_funct3,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic [RD_WIDTH-1:0]   ex_rd,
  input  logic                  ex_write_reg,
  input  logic                  flush,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic                  wb_write,
  output logic [RD_WIDTH-1:0]   wb_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  mem_exc
);

  lsu_state_e state_r, state_nxt_s;

  logic mem_op_s, legal_s, accept_s, exc_s, pass_s, done_s, stall_s;

  logic [1:0]            al_off_s;
  logic [2:0]            al_f3_s;
  logic [3:0]            al_wstrb_s;
  logic [DATA_WIDTH-1:0] al_wdata_s, al_load_s;

  logic                  mem_req_r, mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [3:0]            mem_wstrb_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;

  // Per-access context kept for the load extraction at ack time.
  logic [2:0]            acc_f3_r;
  logic [1:0]            acc_off_r;
  logic [RD_WIDTH-1:0]   acc_rd_r;
  logic                  acc_write_r, acc_load_r, acc_flushed_r;

  logic                  wb_valid_r, wb_write_r, mem_exc_r;
  logic [RD_WIDTH-1:0]   wb_reg_r;
  logic [DATA_WIDTH-1:0] wb_data_r;

  // Next-state decode and classification of the incoming EX bundle.
  always_comb begin
    mem_op_s    = ex_load | ex_store;
    legal_s     = lsu_width_ok(ex_load, ex_store, ex_funct3) &&
                  !lsu_misaligned(ex_funct3, ex_alu_result[1:0]);
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    exc_s       = 1'b0;
    pass_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ex_valid) begin
          if (!mem_op_s) begin
            pass_s = 1'b1;
          end else if (legal_s) begin
            accept_s    = 1'b1;
            state_nxt_s = ST_WAIT_ACK;
          end else begin
            exc_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (mem_ack) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // Combinational so upstream holds on the very cycle the access is taken.
    stall_s = (state_r == ST_WAIT_ACK) || accept_s;
  end

  // The single aligner serves the store path from the live EX bundle while
  // idle and the load path from the latched context while waiting for ack.
  always_comb begin
    if (state_r == ST_WAIT_ACK) begin
      al_off_s = acc_off_r;
      al_f3_s  = acc_f3_r;
    end else begin
      al_off_s = ex_alu_result[1:0];
      al_f3_s  = ex_funct3;
    end
  end

  mem_stage_lsu_align u_align (
    .addr_lo    (al_off_s),
    .funct3     (al_f3_s),
    .store_data (ex_store_data),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb_s),
    .wdata      (al_wdata_s),
    .load_data  (al_load_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Memory request, access context and writeback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= {ADDR_WIDTH{1'b0}};
      mem_wstrb_r   <= 4'b0000;
      mem_wdata_r   <= {DATA_WIDTH{1'b0}};
      acc_f3_r      <= 3'b000;
      acc_off_r     <= 2'b00;
      acc_rd_r      <= {RD_WIDTH{1'b0}};
      acc_write_r   <= 1'b0;
      acc_load_r    <= 1'b0;
      acc_flushed_r <= 1'b0;
      wb_valid_r    <= 1'b0;
      wb_write_r    <= 1'b0;
      wb_reg_r      <= {RD_WIDTH{1'b0}};
      wb_data_r     <= {DATA_WIDTH{1'b0}};
      mem_exc_r     <= 1'b0;
    end else begin
      // Writeback and exception are single-cycle pulses.
      wb_valid_r <= 1'b0;
      wb_write_r <= 1'b0;
      mem_exc_r  <= 1'b0;
      if (pass_s) begin
        wb_valid_r <= !flush;
        wb_write_r <= !flush && ex_write_reg && (ex_rd != {RD_WIDTH{1'b0}});
        wb_reg_r   <= ex_rd;
        wb_data_r  <= ex_alu_result;
      end else if (accept_s) begin
        mem_req_r     <= 1'b1;
        mem_we_r      <= ex_store;
        mem_addr_r    <= {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
        mem_wstrb_r   <= ex_store ? al_wstrb_s : 4'b0000;
        mem_wdata_r   <= ex_store ? al_wdata_s : {DATA_WIDTH{1'b0}};
        acc_f3_r      <= ex_funct3;
        acc_off_r     <= ex_alu_result[1:0];
        acc_rd_r      <= ex_rd;
        acc_write_r   <= ex_write_reg && (ex_rd != {RD_WIDTH{1'b0}});
        acc_load_r    <= ex_load;
        acc_flushed_r <= flush;
      end else if (exc_s) begin
        mem_exc_r <= !flush;
      end else if (done_s) begin
        mem_req_r   <= 1'b0;
        mem_we_r    <= 1'b0;
        mem_wstrb_r <= 4'b0000;
        if (acc_load_r) begin
          // A flush anywhere in the access kills the writeback, not the access.
          wb_valid_r <= !(acc_flushed_r || flush);
          wb_write_r <= !(acc_flushed_r || flush) && acc_write_r;
          wb_reg_r   <= acc_rd_r;
          wb_data_r  <= al_load_s;
        end else begin
          wb_valid_r <= 1'b0;
        end
      end else if ((state_r == ST_WAIT_ACK) && flush) begin
        acc_flushed_r <= 1'b1;
      end else begin
        acc_flushed_r <= acc_flushed_r;
      end
    end
  end

  assign stall     = stall_s;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wstrb = mem_wstrb_r;
  assign mem_wdata = mem_wdata_r;
  assign wb_valid  = wb_valid_r;
  assign wb_write  = wb_write_r;
  assign wb_reg    = wb_reg_r;
  assign wb_data   = wb_data_r;
  assign mem_exc   = mem_exc_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus a randomized
// mix, all checked against a spec-level model of RV32I load/store behaviour.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_load, ex_store, ex_write_reg, flush;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_write, mem_exc;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int n_vec = 0;
  int n_err = 0;

  mem_stage_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_load       (ex_load),
    .ex_store      (ex_store),
    .ex_funct3     (ex_funct3),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_write_reg  (ex_write_reg),
    .flush         (flush),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .wb_valid      (wb_valid),
    .wb_write      (wb_write),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .mem_exc       (mem_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic m_ok(input logic ld, input logic st,
                                input logic [2:0] f3, input logic [31:0] a);
    if (ld == st) return 1'b0;
    if (st && f3 > 3'd2) return 1'b0;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (a % acc_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] rd_word);
    logic [31:0] sh, v;
    sh = rd_word >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd2: v = rd_word;
      3'd4: v = sh & 32'hFF;
      3'd5: v = sh & 32'hFFFF;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = acc_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (acc_size(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // ---------------- transaction drivers ----------------
  task automatic idle_inputs();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
  endtask

  task automatic pass_txn(input logic [31:0] alu, input logic [4:0] rd,
                          input logic wr, input logic fl);
    logic exp_wr;
    exp_wr = wr && (rd != 5'd0) && !fl;
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'($urandom_range(0, 7));
    ex_alu_result = alu; ex_rd = rd; ex_write_reg = wr; flush = fl;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL pass_stall: got %b expected 0", stall); end
    @(negedge clk);
    idle_inputs(); flush = 1'b0;
    #1;
    n_vec++; if (wb_valid !== !fl) begin n_err++; $display("FAIL pass_wb_valid: got %b expected %b", wb_valid, !fl); end
    n_vec++; if (wb_write !== exp_wr) begin n_err++; $display("FAIL pass_wb_write: got %b expected %b", wb_write, exp_wr); end
    if (!fl) begin
      n_vec++; if (wb_data !== alu) begin n_err++; $display("FAIL pass_wb_data: got %h expected %h", wb_data, alu); end
      n_vec++; if (wb_reg !== rd) begin n_err++; $display("FAIL pass_wb_reg: got %0d expected %0d", wb_reg, rd); end
    end
    @(negedge clk);
    #1;
    n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL pass_wb_pulse: got %b expected 0", wb_valid); end
  endtask

  // fl: 0 = no flush, 1 = flush on accept cycle, 2 = flush during wait
  task automatic mem_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic wr, input int k, input int fl);
    logic ok, exp_wbv;
    ok = m_ok(ld, st, f3, addr);
    @(negedge clk);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd; ex_write_reg = wr;
    flush = (fl == 1);
    #1;
    n_vec++; if (stall !== ok) begin n_err++; $display("FAIL accept_stall: got %b expected %b", stall, ok); end
    @(negedge clk);
    idle_inputs(); flush = (fl == 2);
    if (!ok) begin
      #1;
      n_vec++; if (mem_exc !== (fl != 1)) begin n_err++; $display("FAIL exc_pulse: got %b expected %b", mem_exc, fl != 1); end
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL exc_no_req: got %b expected 0", mem_req); end
      n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL exc_no_wb: got %b expected 0", wb_valid); end
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_vec++; if (mem_exc !== 1'b0) begin n_err++; $display("FAIL exc_one_cycle: got %b expected 0", mem_exc); end
      return;
    end
    for (int i = 1; i <= k; i++) begin
      #1;
      n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL req_held: got %b expected 1 (cycle %0d)", mem_req, i); end
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL wait_stall: got %b expected 1", stall); end
      n_vec++; if (mem_addr !== (addr & 32'hFFFF_FFFC)) begin n_err++; $display("FAIL mem_addr: got %h expected %h", mem_addr, addr & 32'hFFFF_FFFC); end
      n_vec++; if (mem_we !== st) begin n_err++; $display("FAIL mem_we: got %b expected %b", mem_we, st); end
      if (st) begin
        n_vec++; if (mem_wstrb !== m_strb(f3, addr)) begin n_err++; $display("FAIL wstrb: got %b expected %b", mem_wstrb, m_strb(f3, addr)); end
        n_vec++; if (mem_wdata !== m_wdata(f3, sdata)) begin n_err++; $display("FAIL wdata: got %h expected %h", mem_wdata, m_wdata(f3, sdata)); end
      end
      n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL early_wb: got %b expected 0", wb_valid); end
      if (i == k) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
      @(negedge clk);
      flush = 1'b0;
    end
    mem_ack = 1'b0; mem_rdata = $urandom;
    exp_wbv = ld && (fl == 0);
    #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL req_drop: got %b expected 0", mem_req); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b expected 0", stall); end
    n_vec++; if (wb_valid !== exp_wbv) begin n_err++; $display("FAIL mem_wb_valid: got %b expected %b", wb_valid, exp_wbv); end
    if (exp_wbv) begin
      n_vec++; if (wb_data !== m_load(f3, addr, rdata)) begin n_err++; $display("FAIL load_data: got %h expected %h", wb_data, m_load(f3, addr, rdata)); end
      n_vec++; if (wb_reg !== rd) begin n_err++; $display("FAIL load_reg: got %0d expected %0d", wb_reg, rd); end
      n_vec++; if (wb_write !== (wr && rd != 5'd0)) begin n_err++; $display("FAIL load_write: got %b expected %b", wb_write, wr && rd != 5'd0); end
    end
    @(negedge clk);
    #1;
    n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL mem_wb_pulse: got %b expected 0", wb_valid); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    ex_funct3 = 3'd0; ex_alu_result = 32'h0; ex_store_data = 32'h0;
    ex_rd = 5'd0; ex_write_reg = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b%b expected 00", mem_req, mem_we); end
    n_vec++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin n_err++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata, mem_wstrb}); end
    n_vec++; if ({wb_valid, wb_write, wb_reg, wb_data} !== 39'h0) begin n_err++; $display("FAIL reset_wb: got %h expected 0", {wb_valid, wb_write, wb_reg, wb_data}); end
    n_vec++; if ({mem_exc, stall} !== 2'b00) begin n_err++; $display("FAIL reset_exc_stall: got %b expected 00", {mem_exc, stall}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_passthrough();
    pass_txn(32'h0000_1234, 5'd5, 1'b1, 1'b0);
    pass_txn(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0);
    pass_txn(32'h0BAD_F00D, 5'd9, 1'b1, 1'b1);
  endtask

  task automatic test_load();
    mem_txn(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 5'd7, 1'b1, 3, 0);
    mem_txn(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF_0000, 5'd7, 1'b1, 3, 0);
    mem_txn(1'b1, 1'b0, 3'd1, 32'h0000_0202, 32'h0, 32'h9234_5678, 5'd3, 1'b1, 1, 0);
    mem_txn(1'b1, 1'b0, 3'd5, 32'h0000_0202, 32'h0, 32'h9234_5678, 5'd3, 1'b1, 2, 0);
  endtask

  task automatic test_store();
    mem_txn(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 5'd1, 1'b0, 2, 0);
    mem_txn(1'b0, 1'b1, 3'd0, 32'h0000_0301, 32'h0000_00A5, 32'h0, 5'd1, 1'b0, 1, 0);
    mem_txn(1'b0, 1'b1, 3'd2, 32'h0000_0400, 32'hCAFE_0123, 32'h0, 5'd1, 1'b0, 4, 0);
  endtask

  task automatic test_exceptions();
    mem_txn(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h0, 5'd4, 1'b1, 1, 0);
    mem_txn(1'b0, 1'b1, 3'd3, 32'h0000_0100, 32'h0, 32'h0, 5'd4, 1'b0, 1, 0);
    mem_txn(1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'h0, 32'h0, 5'd4, 1'b0, 1, 0);
    mem_txn(1'b1, 1'b0, 3'd5, 32'h0000_0103, 32'h0, 32'h0, 5'd4, 1'b1, 1, 0);
    mem_txn(1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'h0, 32'h0, 5'd4, 1'b1, 1, 0);
    mem_txn(1'b1, 1'b0, 3'd7, 32'h0000_0100, 32'h0, 32'h0, 5'd4, 1'b1, 1, 1);
  endtask

  task automatic test_flush();
    mem_txn(1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'h0, 32'h1111_2222, 5'd6, 1'b1, 3, 2);
    mem_txn(1'b1, 1'b0, 3'd2, 32'h0000_0504, 32'h0, 32'h3333_4444, 5'd6, 1'b1, 2, 1);
    mem_txn(1'b1, 1'b0, 3'd0, 32'h0000_0505, 32'h0, 32'h5555_6666, 5'd6, 1'b1, 1, 2);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'd2;
    ex_alu_result = 32'h0000_0040; ex_rd = 5'd8; ex_write_reg = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_pre_req: got %b expected 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_async_req: got %b expected 0", mem_req); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_async_stall: got %b expected 0", stall); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_txn(1'b1, 1'b0, 3'd2, 32'h0000_0044, 32'h0, 32'h7777_8888, 5'd8, 1'b1, 2, 0);
  endtask

  task automatic test_random();
    int unsigned op, fsel;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      op   = $urandom_range(0, 9);
      fsel = $urandom_range(0, 5);
      a    = $urandom;
      if (op < 2) begin
        pass_txn(a, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), fsel == 5);
      end else begin
        mem_txn(op < 6 || op == 9, op >= 6, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 4)), (fsel < 4) ? 0 : int'(fsel) - 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load();
    test_store();
    test_exceptions();
    test_flush();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
